// File: rtl/antena_arb.sv
// ---------------------------------------------------------------------------
// antena_arb
//
// Purpose:
//   Shares a single antenna between N_REQ requesters. An idle arbiter grants
//   the antenna round-robin to one requester, forwards that requester's
//   transmit bit onto the antenna, and after the requester lets go (or, when
//   enabled, after MAX_TX cycles) keeps the antenna quiet for GUARD cycles
//   before arbitrating again.
//
// Parameters:
//   N_REQ   number of requesters (2..8)
//   GUARD   idle guard cycles between transmissions (1..255)
//   MAX_TX  maximum transmit cycles per grant (1..65535), timeout build only
//
// Ports:
//   i_clk      system clock, all state changes on the rising edge
//   i_reset    asynchronous active-high reset
//   i_req      per-requester level-sensitive antenna request
//   i_tx_data  per-requester transmit bit
//   o_grant    one-hot grant, registered
//   o_antena   shared antenna drive, registered
//   o_busy     high while transmitting or in the guard period
//   o_timeout  one-cycle pulse when a grant is revoked at MAX_TX
//
// Configuration:
//   ANTENA_ARB_TIMEOUT_EN  when defined, a grant is revoked after MAX_TX
//                          transmit cycles; when undefined a grant lasts
//                          until the requester drops its request and
//                          o_timeout is tied low.
// ---------------------------------------------------------------------------
module antena_arb #(
    parameter int N_REQ  = 2,
    parameter int GUARD  = 4,
    parameter int MAX_TX = 64
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [N_REQ-1:0] i_req,
    input  logic [N_REQ-1:0] i_tx_data,
    output logic [N_REQ-1:0] o_grant,
    output logic             o_antena,
    output logic             o_busy,
    output logic             o_timeout
);

    localparam int PTR_W = $clog2(N_REQ);
    localparam int GRD_W = $clog2(GUARD + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_TX    = 2'd1,
        S_GUARD = 2'd2
    } state_t;

    state_t             r_state;
    logic [PTR_W-1:0]   r_rr_ptr;
    logic [PTR_W-1:0]   r_idx;
    logic [N_REQ-1:0]   r_grant;
    logic               r_antena;
    logic [GRD_W-1:0]   r_guard_cnt;

`ifdef ANTENA_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(MAX_TX + 1);
    logic [CNT_W-1:0]   r_tx_cnt;
    logic               r_timeout;
`endif

    logic [PTR_W:0]     w_sum;
    logic [PTR_W-1:0]   w_cand;
    logic [PTR_W-1:0]   w_winner;
    logic               w_any_req;
    logic [PTR_W-1:0]   w_next_ptr;
    logic [N_REQ-1:0]   w_onehot;
    logic               w_owner_req;
    logic               w_arb;

    // Round-robin pick: scan from rr_ptr upward with wrap-around. The loop
    // runs from the farthest candidate back to the nearest so that the last
    // hit written is the first asserted request at or after rr_ptr.
    always_comb begin
        w_sum     = '0;
        w_cand    = '0;
        w_winner  = '0;
        w_any_req = 1'b0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            w_sum = {1'b0, r_rr_ptr} + (PTR_W + 1)'(k);
            if (w_sum >= (PTR_W + 1)'(N_REQ)) begin
                w_sum = w_sum - (PTR_W + 1)'(N_REQ);
            end
            w_cand = w_sum[PTR_W-1:0];
            if (i_req[w_cand]) begin
                w_any_req = 1'b1;
                w_winner  = w_cand;
            end
        end
    end

    // Pointer moves just past the winner so the winner has lowest priority
    // next time.
    assign w_next_ptr  = (w_winner == PTR_W'(N_REQ - 1)) ? '0 : (w_winner + 1'b1);
    assign w_onehot    = {{(N_REQ - 1){1'b0}}, 1'b1} << w_winner;
    assign w_owner_req = i_req[r_idx];

    // Arbitration happens in IDLE and also on the final guard edge, so the
    // antenna is quiet for exactly GUARD cycles between back-to-back grants.
    // Any unused state encoding arbitrates too, which recovers it to IDLE/TX.
    assign w_arb = ((r_state != S_TX) && (r_state != S_GUARD)) ||
                   ((r_state == S_GUARD) && (r_guard_cnt == GRD_W'(GUARD)));

    // Main arbiter FSM. All outputs are registered here; reset clears them
    // asynchronously so a reset mid-transmission drops the antenna at once
    // without running a guard period.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state     <= S_IDLE;
            r_rr_ptr    <= '0;
            r_idx       <= '0;
            r_grant     <= '0;
            r_antena    <= 1'b0;
            r_guard_cnt <= '0;
`ifdef ANTENA_ARB_TIMEOUT_EN
            r_tx_cnt    <= '0;
            r_timeout   <= 1'b0;
`endif
        end else begin
`ifdef ANTENA_ARB_TIMEOUT_EN
            r_timeout <= 1'b0;
`endif
            case (r_state)
                S_TX: begin
                    // A release on the same edge as the MAX_TX limit is a
                    // normal release, hence it is tested first.
                    if (!w_owner_req) begin
                        r_state     <= S_GUARD;
                        r_grant     <= '0;
                        r_antena    <= 1'b0;
                        r_guard_cnt <= GRD_W'(1);
                    end
`ifdef ANTENA_ARB_TIMEOUT_EN
                    else if (r_tx_cnt == CNT_W'(MAX_TX)) begin
                        r_state     <= S_GUARD;
                        r_grant     <= '0;
                        r_antena    <= 1'b0;
                        r_guard_cnt <= GRD_W'(1);
                        r_timeout   <= 1'b1;
                    end
`endif
                    else begin
                        r_antena <= i_tx_data[r_idx];
`ifdef ANTENA_ARB_TIMEOUT_EN
                        r_tx_cnt <= r_tx_cnt + 1'b1;
`endif
                    end
                end
                default: begin
                    if (w_arb) begin
                        r_guard_cnt <= '0;
                        if (w_any_req) begin
                            r_state  <= S_TX;
                            r_grant  <= w_onehot;
                            r_idx    <= w_winner;
                            r_rr_ptr <= w_next_ptr;
                            r_antena <= i_tx_data[w_winner];
`ifdef ANTENA_ARB_TIMEOUT_EN
                            r_tx_cnt <= CNT_W'(1);
`endif
                        end else begin
                            r_state  <= S_IDLE;
                            r_grant  <= '0;
                            r_antena <= 1'b0;
                        end
                    end else begin
                        r_guard_cnt <= r_guard_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    assign o_grant  = r_grant;
    assign o_antena = r_antena;
    assign o_busy   = (r_state == S_TX) || (r_state == S_GUARD);

`ifdef ANTENA_ARB_TIMEOUT_EN
    assign o_timeout = r_timeout;
`else
    assign o_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_antena_arb.sv
// ---------------------------------------------------------------------------
// tb_antena_arb
//
// Self-checking bench for antena_arb (N_REQ=2, GUARD=4, MAX_TX=8). A
// behavioural model tracks who owns the antenna, how long it has
// transmitted, how many quiet cycles remain and the round-robin pointer;
// every falling edge the DUT outputs are compared with it. Directed
// scenarios at the start add literal expectations, followed by random
// traffic with occasional resets.
// ---------------------------------------------------------------------------
module tb_antena_arb;

    localparam int N_REQ  = 2;
    localparam int GUARD  = 4;
    localparam int MAX_TX = 8;

`ifdef ANTENA_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic             i_clk     = 1'b0;
    logic             i_reset   = 1'b1;
    logic [N_REQ-1:0] i_req     = '0;
    logic [N_REQ-1:0] i_tx_data = '0;
    logic [N_REQ-1:0] o_grant;
    logic             o_antena;
    logic             o_busy;
    logic             o_timeout;

    int nTests = 0;
    int nFail  = 0;

    // Behavioural model state
    int owner     = -1;
    int txCycles  = 0;
    int guardLeft = 0;
    int rr        = 0;
    bit antExp    = 1'b0;
    bit toExp     = 1'b0;

    antena_arb #(
        .N_REQ  (N_REQ),
        .GUARD  (GUARD),
        .MAX_TX (MAX_TX)
    ) dut (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_req     (i_req),
        .i_tx_data (i_tx_data),
        .o_grant   (o_grant),
        .o_antena  (o_antena),
        .o_busy    (o_busy),
        .o_timeout (o_timeout)
    );

    always #5 i_clk = ~i_clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nTests++;
        if (act !== exp) begin
            nFail++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic [N_REQ-1:0] r, input logic [N_REQ-1:0] d);
        i_req     = r;
        i_tx_data = d;
    endtask

    // Reference model: advances once per rising edge from the sampled inputs.
    always @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            owner     = -1;
            txCycles  = 0;
            guardLeft = 0;
            rr        = 0;
            antExp    = 1'b0;
            toExp     = 1'b0;
        end else begin
            toExp = 1'b0;
            if (owner >= 0) begin
                if (!i_req[owner]) begin
                    owner     = -1;
                    guardLeft = GUARD;
                    antExp    = 1'b0;
                end else if (TO_EN && txCycles == MAX_TX) begin
                    owner     = -1;
                    guardLeft = GUARD;
                    antExp    = 1'b0;
                    toExp     = 1'b1;
                end else begin
                    txCycles++;
                    antExp = i_tx_data[owner];
                end
            end else if (guardLeft > 1) begin
                guardLeft--;
            end else begin
                bit found;
                found     = 1'b0;
                guardLeft = 0;
                antExp    = 1'b0;
                for (int k = 0; k < N_REQ; k++) begin
                    int cand;
                    cand = (rr + k) % N_REQ;
                    if (!found && i_req[cand]) begin
                        found    = 1'b1;
                        owner    = cand;
                        txCycles = 1;
                        antExp   = i_tx_data[cand];
                    end
                end
                if (found) rr = (owner + 1) % N_REQ;
            end
        end
    end

    // Continuous comparison against the model, away from the active edge.
    always @(negedge i_clk) begin
        checkOutput("grant",   32'(o_grant), (owner >= 0) ? (32'd1 << owner) : 32'd0);
        checkOutput("antena",  32'(o_antena), 32'(antExp));
        checkOutput("busy",    32'(o_busy), 32'((owner >= 0) || (guardLeft > 0)));
        checkOutput("timeout", 32'(o_timeout), 32'(toExp));
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        repeat (3) @(negedge i_clk);
        checkOutput("reset_grant", 32'(o_grant), 32'd0);
        checkOutput("reset_busy",  32'(o_busy), 32'd0);

        // Both request after reset: requester 0 first, requester 1 after guard
        i_reset = 1'b0;
        applyStimulus(2'b11, 2'b00);
        @(negedge i_clk);
        checkOutput("a_first_grant", 32'(o_grant), 32'h1);
        applyStimulus(2'b10, 2'b00);
        for (int k = 0; k < GUARD; k++) begin
            @(negedge i_clk);
            checkOutput("a_guard_grant", 32'(o_grant), 32'h0);
        end
        @(negedge i_clk);
        checkOutput("a_second_grant", 32'(o_grant), 32'h2);
        applyStimulus(2'b00, 2'b00);
        repeat (GUARD + 3) @(negedge i_clk);

        // Requester 1 alone, data 1,0,1, then antenna silent during guard
        applyStimulus(2'b10, 2'b10);
        @(negedge i_clk);
        checkOutput("b_grant", 32'(o_grant), 32'h2);
        checkOutput("b_ant_1", 32'(o_antena), 32'h1);
        applyStimulus(2'b10, 2'b00);
        @(negedge i_clk);
        checkOutput("b_ant_0", 32'(o_antena), 32'h0);
        applyStimulus(2'b10, 2'b10);
        @(negedge i_clk);
        checkOutput("b_ant_1b", 32'(o_antena), 32'h1);
        applyStimulus(2'b00, 2'b10);
        for (int k = 0; k < GUARD; k++) begin
            @(negedge i_clk);
            checkOutput("b_guard_ant", 32'(o_antena), 32'h0);
        end
        repeat (3) @(negedge i_clk);
        applyStimulus(2'b00, 2'b00);

        // Requester 0 held 20 cycles; released exactly when tx count is at max
        applyStimulus(2'b01, 2'b00);
        for (int obs = 1; obs <= 20; obs++) begin
            @(negedge i_clk);
            checkOutput("c_grant0", 32'(o_grant[0]),
                        TO_EN ? 32'((obs <= MAX_TX) || (obs >= MAX_TX + GUARD + 1)) : 32'd1);
            checkOutput("c_timeout", 32'(o_timeout), 32'(TO_EN && (obs == MAX_TX + 1)));
        end
        applyStimulus(2'b00, 2'b00);
        @(negedge i_clk);
        checkOutput("c_release_grant",   32'(o_grant), 32'h0);
        checkOutput("c_release_timeout", 32'(o_timeout), 32'h0);
        checkOutput("c_release_busy",    32'(o_busy), 32'h1);
        repeat (GUARD + 2) @(negedge i_clk);

        // Round-robin favours requester 1 now; reset at TX cycle 3
        applyStimulus(2'b11, 2'b11);
        @(negedge i_clk);
        checkOutput("e_rr_grant", 32'(o_grant), 32'h2);
        repeat (2) @(negedge i_clk);
        checkOutput("e_ant_before_reset", 32'(o_antena), 32'h1);
        #2 i_reset = 1'b1;
        #1;
        checkOutput("e_reset_grant",  32'(o_grant), 32'h0);
        checkOutput("e_reset_antena", 32'(o_antena), 32'h0);
        checkOutput("e_reset_busy",   32'(o_busy), 32'h0);
        @(negedge i_clk);
        i_reset = 1'b0;
        @(negedge i_clk);
        checkOutput("e_after_reset", 32'(o_grant), 32'h1);

        // Random traffic: requests held for several cycles, rare resets
        for (int c = 0; c < 3000; c++) begin
            @(negedge i_clk);
            if ($urandom_range(0, 11) == 0) i_req = N_REQ'($urandom);
            i_tx_data = N_REQ'($urandom);
            if ($urandom_range(0, 499) == 0) begin
                #2 i_reset = 1'b1;
                @(negedge i_clk);
                i_reset = 1'b0;
            end
        end

        @(negedge i_clk);
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule

// File: doc/antena_arb.md
ANTENA_ARB -- requirements
Module: antena_arb

Interface
REQ-001 Parameter N_REQ, default 2, number of SoC requesters sharing the antenna (2..8).
REQ-002 Parameter GUARD, default 4, idle guard cycles between transmissions (1..255).
REQ-003 Parameter MAX_TX, default 64, maximum transmit cycles per grant (1..65535).
REQ-004 clk  input  1  single system clock; all state changes on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 req  input  N_REQ  per-requester antenna request, level-sensitive.
REQ-007 tx_data  input  N_REQ  per-requester transmit bit.
REQ-008 grant  output  N_REQ  one-hot antenna grant, registered.
REQ-009 antena  output  1  shared antenna drive, registered.
REQ-010 busy  output  1  high while in TX or GUARD state.
REQ-011 timeout  output  1  single-cycle pulse when a grant is revoked at MAX_TX.

Function
REQ-012 The FSM SHALL have three states: IDLE, TX, GUARD.
REQ-013 IDLE: if req != 0, go to TX and set grant to the winner on the same edge; first grant high one cycle after req is sampled.
REQ-014 Winner SHALL be chosen round-robin: first asserted req at index >= rr_ptr, wrapping modulo N_REQ.
REQ-015 On entering TX with winner i, rr_ptr SHALL become (i+1) mod N_REQ.
REQ-016 TX: grant SHALL hold constant; tx_cnt counts 1..MAX_TX, incrementing each cycle in TX.
REQ-017 TX -> GUARD when req[i] of the granted requester is sampled low; grant clears on that edge.
REQ-018 antena SHALL equal tx_data[i] of the granted requester, registered (one-cycle latency), and 0 whenever grant is 0.
REQ-019 Requests from non-granted requesters during TX or GUARD SHALL be ignored, not latched; they win only if still asserted in IDLE.
REQ-020 GUARD: grant = 0, antena = 0 for exactly GUARD cycles, then IDLE.
REQ-021 IDLE with req = 0: remain in IDLE, grant = 0, busy = 0.
REQ-022 Simultaneous req deassertion and tx_cnt reaching MAX_TX: treated as normal release; timeout SHALL NOT pulse.
REQ-023 grant SHALL never have more than one bit set; at most one requester drives the antenna.

Reset
REQ-024 While reset is high: state = IDLE, grant = 0, antena = 0, busy = 0, timeout = 0, tx_cnt = 0, guard counter = 0, rr_ptr = 0.
REQ-025 Reset asserted mid-TX or mid-GUARD SHALL drop grant and antena immediately (asynchronously), with no guard period executed.
REQ-026 After reset deassertion, the first arbitration SHALL favour requester 0.

Configuration
REQ-027 Macro ANTENA_ARB_TIMEOUT_EN defined: in TX, when tx_cnt = MAX_TX and req[i] is still high, grant clears, timeout pulses one cycle, FSM enters GUARD.
REQ-028 Macro ANTENA_ARB_TIMEOUT_EN undefined: no MAX_TX limit, tx_cnt unused, timeout tied to 0, grant held until req[i] deasserts.

Verification (N_REQ=2, GUARD=4, MAX_TX=8, ANTENA_ARB_TIMEOUT_EN defined unless stated)
REQ-029 After reset, req=2'b11 held -> grant=2'b01 one cycle later; after req[0] drops, 4 cycles grant=0, then grant=2'b10.
REQ-030 req[1] only, tx_data[1] toggling 1,0,1 -> antena 1,0,1 one cycle delayed; antena=0 throughout GUARD.
REQ-031 req[0] held 20 cycles -> grant[0] high exactly 8 cycles, timeout pulse 1 cycle at revoke, 4 guard cycles, then re-grant to requester 0 (requester 1 idle).
REQ-032 Same stimulus with ANTENA_ARB_TIMEOUT_EN undefined -> grant[0] high for all 20 cycles, timeout never asserted.
REQ-033 reset pulsed at TX cycle 3 -> grant=0, antena=0, busy=0 within the reset cycle; after release with req=2'b11, grant=2'b01.
REQ-034 req[0] drops on the cycle tx_cnt=8 -> GUARD entered, timeout stays 0.
